preg_file_mp: RTL

//   Multi-port physical register file for the R10K back end; the parametrised successor of the 2R/1W PRF.

---
 rtl/preg_file_mp.sv | 133 +++++++++++++
 1 files changed

// File: rtl/preg_file_mp.sv
// Multi-port physical register file with per-register ready bits, write-to-read
// bypass, a hard-wired zero register and optionally registered read ports.
module preg_file_mp #(
    parameter int NUM_REGS = 64,
    parameter int DATA_W   = 64,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int RD_PORTS = 4,
    parameter int WR_PORTS = 2,
    parameter int AL_PORTS = 1,
    parameter int ZERO_IDX = NUM_REGS - 1,
    parameter int READ_REG = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS*IDX_W-1:0]    rd_idx_i,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data_o,
    output logic [RD_PORTS-1:0]          rd_rdy_o,
    input  logic [WR_PORTS-1:0]          wr_en_i,
    input  logic [WR_PORTS*IDX_W-1:0]    wr_idx_i,
    input  logic [WR_PORTS*DATA_W-1:0]   wr_data_i,
    input  logic [AL_PORTS-1:0]          al_en_i,
    input  logic [AL_PORTS*IDX_W-1:0]    al_idx_i
);

    localparam logic [IDX_W-1:0] ZERO = IDX_W'(ZERO_IDX);

    logic [IDX_W-1:0]  wr_idx  [WR_PORTS];
    logic [DATA_W-1:0] wr_data [WR_PORTS];
    logic [IDX_W-1:0]  al_idx  [AL_PORTS];

    logic [DATA_W-1:0] data_all [NUM_REGS];
    logic [NUM_REGS-1:0] rdy_all;

    genvar gi;

    for (gi = 0; gi < WR_PORTS; gi++) begin : g_wr_unpack
        assign wr_idx[gi]  = wr_idx_i[gi*IDX_W +: IDX_W];
        assign wr_data[gi] = wr_data_i[gi*DATA_W +: DATA_W];
    end

    for (gi = 0; gi < AL_PORTS; gi++) begin : g_al_unpack
        assign al_idx[gi] = al_idx_i[gi*IDX_W +: IDX_W];
    end

    // One storage slot per register; indices >= NUM_REGS match no slot and are dropped.
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == ZERO_IDX) begin : g_zero
            assign data_all[gi] = '0;
            assign rdy_all[gi]  = 1'b1;
        end else begin : g_live
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] data_next;
            logic              rdy_reg;
            logic              rdy_next;

            // Later write ports override earlier ones; allocate overrides any writeback.
            always_comb begin
                data_next = data_reg;
                rdy_next  = rdy_reg;
                for (int w = 0; w < WR_PORTS; w++) begin
                    if (wr_en_i[w] && (wr_idx[w] == IDX_W'(gi))) begin
                        data_next = wr_data[w];
                        rdy_next  = 1'b1;
                    end
                end
                for (int a = 0; a < AL_PORTS; a++) begin
                    if (al_en_i[a] && (al_idx[a] == IDX_W'(gi))) begin
                        rdy_next = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                    rdy_reg  <= 1'b1;
                end else begin
                    data_reg <= data_next;
                    rdy_reg  <= rdy_next;
                end
            end

            assign data_all[gi] = data_reg;
            assign rdy_all[gi]  = rdy_reg;
        end
    end

    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data_next;
        logic              rdy_next;

        assign idx = rd_idx_i[gi*IDX_W +: IDX_W];

        // Zero register beats bypass, bypass beats storage; allocates are not bypassed.
        always_comb begin
            data_next = data_all[idx];
            rdy_next  = rdy_all[idx];
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_en_i[w] && (wr_idx[w] == idx)) begin
                    data_next = wr_data[w];
                    rdy_next  = 1'b1;
                end
            end
            if (idx == ZERO) begin
                data_next = '0;
                rdy_next  = 1'b1;
            end
        end

        if (READ_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] data_reg;
            logic              rdy_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                    rdy_reg  <= 1'b0;
                end else begin
                    data_reg <= data_next;
                    rdy_reg  <= rdy_next;
                end
            end

            assign rd_data_o[gi*DATA_W +: DATA_W] = data_reg;
            assign rd_rdy_o[gi]                   = rdy_reg;
        end else begin : g_out_comb
            assign rd_data_o[gi*DATA_W +: DATA_W] = data_next;
            assign rd_rdy_o[gi]                   = rdy_next;
        end
    end

endmodule
